// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA display geometry, RGB444 colours, box FSM states and bounce helper.
package vga_pkg;
    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;
    localparam int HMAX      = 799;
    localparam int VMAX      = 524;

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_BLUE   = 12'h00F;
    localparam logic [11:0] RGB_YELLOW = 12'hFF0;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    // One axis of the bounce: returns {new_dir, new_pos}, dir=1 means increasing.
    // The limit is clamped exactly so the box never leaves the screen.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                           input logic [9:0] lim, input logic [9:0] spd);
        logic [10:0] up;
        up = {1'b0, pos} + {1'b0, spd};
        if (dir)
            return (up >= {1'b0, lim}) ? {1'b0, lim} : {1'b1, pos + spd};
        return (pos <= spd) ? {1'b1, 10'd0} : {1'b0, pos - spd};
    endfunction
endpackage

// File: rtl/box_motion.sv
// box_motion: IDLE/RUN/PAUSE control and once-per-frame bounce of the box position.
//   clk, reset (async active-low), frame_tick (one-clk frame strobe),
//   start/pause (levels sampled on frame_tick), box_x/box_y (top-left corner).
module box_motion
    import vga_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int SPEED    = 2
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       pause,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);
    localparam int MAXX = H_DISPLAY - BOX_SIZE;
    localparam int MAXY = V_DISPLAY - BOX_SIZE;

    state_t state, state_nx;
    logic   move;
    logic   dir_x, dir_y;

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb begin
        state_nx = state;
        if (frame_tick)
            case (state)
                IDLE:    state_nx = start ? RUN : IDLE;
                RUN:     state_nx = pause ? PAUSE : RUN;
                PAUSE:   state_nx = pause ? PAUSE : RUN;
                default: state_nx = IDLE;
            endcase
    end

    // pause wins over movement on the same tick, so only a RUN tick without pause moves.
    always_comb move = frame_tick && state == RUN && !pause;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            box_x <= 10'(MAXX / 2);
            box_y <= 10'(MAXY / 2);
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (move) begin
            {dir_x, box_x} <= bounce(box_x, dir_x, 10'(MAXX), 10'(SPEED));
            {dir_y, box_y} <= bounce(box_y, dir_y, 10'(MAXY), 10'(SPEED));
        end
endmodule

// File: rtl/pixel_gen.sv
// pixel_gen: renders a bouncing box over a solid background with sync delay-matched to rgb.
//   clk, reset (async active-low), pix_en (pixel-rate enable), x/y/video_on/hsync_in/vsync_in
//   from the timing controller, start/pause run control, rgb (RGB444), hsync_out/vsync_out
//   (2 pix_en behind their inputs, aligned with rgb), frame_tick (one clk at blanking start).
module pixel_gen
    import vga_pkg::*;
#(
    parameter int          BOX_SIZE  = 32,
    parameter int          SPEED     = 2,
    parameter logic [11:0] BG_COLOR  = RGB_BLUE,
    parameter logic [11:0] BOX_COLOR = RGB_YELLOW
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        start,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        frame_tick
);
    logic [9:0] box_x, box_y;
    logic       in_box, in_box_d, video_on_d, hsync_d, vsync_d;

    box_motion #(.BOX_SIZE(BOX_SIZE), .SPEED(SPEED)) u_motion (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .pause      (pause),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    // First blanking pixel of the frame; the box only moves here so no frame tears.
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            frame_tick <= 1'b0;
        else
            frame_tick <= pix_en && x == 10'd0 && y == 10'(V_DISPLAY);

    // 11-bit upper bounds so box_x+BOX_SIZE cannot wrap.
    assign in_box = (x >= box_x) && ({1'b0, x} < {1'b0, box_x} + 11'(BOX_SIZE)) &&
                    (y >= box_y) && ({1'b0, y} < {1'b0, box_y} + 11'(BOX_SIZE));

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            in_box_d   <= 1'b0;
            video_on_d <= 1'b0;
            hsync_d    <= 1'b0;
            vsync_d    <= 1'b0;
            rgb        <= RGB_BLACK;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
        end else if (pix_en) begin
            in_box_d   <= in_box;
            video_on_d <= video_on;
            hsync_d    <= hsync_in;
            vsync_d    <= vsync_in;
            rgb        <= !video_on_d ? RGB_BLACK : in_box_d ? BOX_COLOR : BG_COLOR;
            hsync_out  <= hsync_d;
            vsync_out  <= vsync_d;
        end
endmodule

// File: tb/tb_pixel_gen.sv
// tb_pixel_gen: directed self-checking bench for pixel_gen.
module tb_pixel_gen;
    import vga_pkg::*;

    localparam logic [11:0] BG  = 12'h00F;
    localparam logic [11:0] BOX = 12'hFF0;

    logic        clk = 0, reset = 1, pix_en = 0, video_on = 0;
    logic        hsync_in = 0, vsync_in = 0, start = 0, pause = 0;
    logic [9:0]  x = 10'd700, y = 10'd500;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out, frame_tick;
    int          passed = 0, failed = 0, total = 0;

    logic [9:0]  xs [6] = '{10'd310, 10'd100, 10'd700, 10'd320, 10'd50, 10'd311};
    logic        hs [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        vs [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [11:0] cs [6] = '{BOX, BG, 12'h000, BOX, BG, BOX};

    always #5 clk = ~clk;

    pixel_gen dut (
        .clk        (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .x          (x),
        .y          (y),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .start      (start),
        .pause      (pause),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_tick (frame_tick)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [9:0] px, input logic [9:0] py, input logic h, input logic v);
        x = px;
        y = py;
        video_on = px < 10'd640 && py < 10'd480;
        hsync_in = h;
        vsync_in = v;
        pix_en = 1;
        @(posedge clk);
        #1;
        pix_en = 0;
    endtask

    task automatic pix(input string tag, input logic [9:0] px, input logic [9:0] py,
                       input logic [11:0] exp);
        feed(px, py, 0, 0);
        feed(10'd700, 10'd500, 0, 0);
        check(tag, rgb, exp);
    endtask

    task automatic tick();
        feed(10'd0, 10'd480, 0, 0);
        check("tick_hi", frame_tick, 1);
        x = 10'd1;
        @(posedge clk);
        #1;
        check("tick_lo", frame_tick, 0);
    endtask

    task automatic pos(input string tag, input logic [9:0] ex, input logic [9:0] ey);
        check({tag, "_x"}, dut.box_x, ex);
        check({tag, "_y"}, dut.box_y, ey);
    endtask

    initial begin
        #1 reset = 0;
        #20;
        check("rst_rgb", rgb, 0);
        check("rst_hs", hsync_out, 0);
        check("rst_vs", vsync_out, 0);
        check("rst_ft", frame_tick, 0);
        check("rst_state", 32'(dut.u_motion.state), 32'(IDLE));
        pos("rst", 10'd304, 10'd224);
        @(posedge clk);
        #1 reset = 1;

        tick();
        tick();
        pos("idle", 10'd304, 10'd224);
        pix("centre", 10'd304, 10'd224, BOX);
        pix("origin", 10'd0, 10'd0, BG);
        pix("blank_h", 10'd700, 10'd10, 12'h000);
        pix("blank_v", 10'd10, 10'd490, 12'h000);
        pix("box_br", 10'd335, 10'd255, BOX);
        pix("right_out", 10'd336, 10'd224, BG);
        pix("below_out", 10'd304, 10'd256, BG);
        pix("left_out", 10'd303, 10'd224, BG);

        for (int k = 0; k < 6; k++) begin
            feed(xs[k], 10'd230, hs[k], vs[k]);
            if (k > 0) begin
                check("lat_hs", hsync_out, hs[k-1]);
                check("lat_vs", vsync_out, vs[k-1]);
                check("lat_rgb", rgb, cs[k-1]);
            end
        end
        x = 10'd0;
        y = 10'd0;
        video_on = 1;
        hsync_in = 1;
        vsync_in = 0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_rgb", rgb, cs[4]);
        check("hold_hs", hsync_out, hs[4]);
        check("hold_vs", vsync_out, vs[4]);

        feed(10'd1, 10'd480, 0, 0);
        check("no_tick_x1", frame_tick, 0);
        feed(10'd0, 10'd481, 0, 0);
        check("no_tick_y481", frame_tick, 0);
        x = 10'd0;
        y = 10'd480;
        @(posedge clk);
        #1;
        check("no_tick_noen", frame_tick, 0);

        start = 1;
        tick();
        start = 0;
        check("run_state", 32'(dut.u_motion.state), 32'(RUN));
        pos("enter_run", 10'd304, 10'd224);
        tick();
        pos("first_move", 10'd306, 10'd226);
        pix("old_corner", 10'd305, 10'd225, BG);
        pix("new_corner", 10'd306, 10'd226, BOX);

        pause = 1;
        tick();
        check("pause_state", 32'(dut.u_motion.state), 32'(PAUSE));
        tick();
        tick();
        pos("paused", 10'd306, 10'd226);
        pause = 0;
        tick();
        check("resume_state", 32'(dut.u_motion.state), 32'(RUN));
        pos("resume", 10'd306, 10'd226);
        tick();
        pos("moving", 10'd308, 10'd228);
        start = 1;
        tick();
        start = 0;
        check("start_ign", 32'(dut.u_motion.state), 32'(RUN));
        pos("start_ign", 10'd310, 10'd230);

        for (int k = 0; k < 148; k++) tick();
        pos("pre_edge", 10'd606, 10'd370);
        tick();
        pos("at_maxx", 10'd608, 10'd368);
        pix("right_edge", 10'd639, 10'd368, BOX);
        pix("left_of_box", 10'd607, 10'd368, BG);
        tick();
        pos("off_maxx", 10'd606, 10'd366);
        for (int k = 0; k < 183; k++) tick();
        pos("at_top", 10'd240, 10'd0);
        tick();
        pos("off_top", 10'd238, 10'd2);

        feed(10'd100, 10'd100, 1, 1);
        feed(10'd101, 10'd100, 1, 1);
        check("pre_rst_rgb", rgb, BG);
        check("pre_rst_hs", hsync_out, 1);
        reset = 0;
        #1;
        check("mid_rst_rgb", rgb, 0);
        check("mid_rst_hs", hsync_out, 0);
        check("mid_rst_vs", vsync_out, 0);
        @(posedge clk);
        #1 reset = 1;
        check("post_rst_state", 32'(dut.u_motion.state), 32'(IDLE));
        pos("post_rst", 10'd304, 10'd224);
        feed(10'd304, 10'd224, 1, 0);
        check("post_rst_p1", rgb, 0);
        feed(10'd700, 10'd500, 0, 0);
        check("post_rst_p2", rgb, BOX);
        check("post_rst_hs", hsync_out, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
